vga_rom_arbiter: RTL and testbench

Shares the single-read-port, 1-cycle-latency image ROM between two requesters: display scanout and a host read port used for overlay or debug reads.
- Scanout always has priority. It converts (x, y) pixel coordinates into a linear ROM address and returns pixels in a fixed-latency pipeline.
- Host reads are slotted into cycles where the display does not need the ROM. They use a req/ack handshake.
- Sits between the VGA timing generator, the ROM and the host/overlay logic.

---
 rtl/vga_rom_arbiter_if.sv | 45 ++++
 rtl/vga_rom_arbiter.sv | 154 +++++++++++++++
 tb/tb_vga_rom_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_rom_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : vga_rom_arbiter_if
// Brief  : Display, host and ROM signal bundle for vga_rom_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
interface vga_rom_arbiter_if #(
   parameter int ADDR_WIDTH = 24,
   parameter int DATA_WIDTH = 24
);
   logic                  i_disp_active;
   logic [9:0]            i_disp_x;
   logic [9:0]            i_disp_y;
   logic [DATA_WIDTH-1:0] o_disp_pixel;
   logic                  o_disp_valid;

   logic                  i_host_req;
   logic [ADDR_WIDTH-1:0] i_host_addr;
   logic [DATA_WIDTH-1:0] o_host_rdata;
   logic                  o_host_ack;

   logic [ADDR_WIDTH-1:0] o_rom_addr;
   logic [DATA_WIDTH-1:0] i_rom_rdata;

   // Arbiter side
   modport slave (
      input  i_disp_active, i_disp_x, i_disp_y,
      output o_disp_pixel, o_disp_valid,
      input  i_host_req, i_host_addr,
      output o_host_rdata, o_host_ack,
      output o_rom_addr,
      input  i_rom_rdata
   );

   // Environment side: timing generator, host and ROM
   modport master (
      output i_disp_active, i_disp_x, i_disp_y,
      input  o_disp_pixel, o_disp_valid,
      output i_host_req, i_host_addr,
      input  o_host_rdata, o_host_ack,
      input  o_rom_addr,
      output i_rom_rdata
   );
endinterface
`default_nettype wire

// File: rtl/vga_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module : vga_rom_arbiter
// Brief  : Shares a 1-cycle-latency ROM between display scanout (priority)
//          and a req/ack host read port. Optional: HOST_STARVE_GUARD_EN.
// Rev    : 1.0  initial release
// ============================================================================
module vga_rom_arbiter #(
   parameter int                    DISPLAY_WIDTH  = 640,
   parameter int                    DISPLAY_HEIGHT = 480,
   parameter int                    DATA_WIDTH     = 24,
   parameter int                    ADDR_WIDTH     = 24,
   parameter logic [DATA_WIDTH-1:0] BLANK_PIXEL    = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   vga_rom_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT1 = 2'd1,
      S_WAIT2 = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_DISP = 2'd1,
      OWN_HOST = 2'd2
   } owner_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  w_grant;
   logic                  w_disp_take;
   logic                  w_force;
   logic [ADDR_WIDTH-1:0] w_disp_addr;
   logic                  w_disp_oor;

   logic [ADDR_WIDTH-1:0] r_rom_addr;
   owner_t                r_own0;
   owner_t                r_own1;
   logic                  r_blank0;
   logic                  r_blank1;
   logic [DATA_WIDTH-1:0] r_disp_pixel;
   logic                  r_disp_valid;
   logic [DATA_WIDTH-1:0] r_host_rdata;
   logic                  r_host_ack;

   // Linear address computed at full ROM width so no in-range product wraps
   always_comb begin
      w_disp_addr = ADDR_WIDTH'(bus.i_disp_y) * ADDR_WIDTH'(DISPLAY_WIDTH)
                  + ADDR_WIDTH'(bus.i_disp_x);
      w_disp_oor  = ({22'd0, bus.i_disp_x} >= 32'(DISPLAY_WIDTH)) ||
                    ({22'd0, bus.i_disp_y} >= 32'(DISPLAY_HEIGHT));
   end

`ifdef HOST_STARVE_GUARD_EN
   logic [3:0] r_starve_cnt;

   assign w_force = (r_starve_cnt == 4'd15);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_starve_cnt <= 4'd0;
      end else if (w_grant) begin
         r_starve_cnt <= 4'd0;
      end else if ((r_state == S_IDLE) && bus.i_host_req &&
                   bus.i_disp_active && !w_force) begin
         r_starve_cnt <= r_starve_cnt + 4'd1;
      end
   end
`else
   assign w_force = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // DONE never grants, giving the host one cycle to release its request
   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.i_host_req && (!bus.i_disp_active || w_force)) begin
               w_grant     = 1'b1;
               w_state_nxt = S_WAIT1;
            end
         end
         S_WAIT1: w_state_nxt = S_WAIT2;
         S_WAIT2: w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // A forced host grant steals the slot, so that display request is dropped
   assign w_disp_take = bus.i_disp_active && !w_grant;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rom_addr <= '0;
         r_own0     <= OWN_NONE;
         r_own1     <= OWN_NONE;
         r_blank0   <= 1'b0;
         r_blank1   <= 1'b0;
      end else begin
         if (w_grant) begin
            r_rom_addr <= bus.i_host_addr;
         end else if (w_disp_take) begin
            r_rom_addr <= w_disp_addr;
         end
         r_own0   <= w_grant     ? OWN_HOST :
                     w_disp_take ? OWN_DISP : OWN_NONE;
         r_blank0 <= w_disp_take && w_disp_oor;
         r_own1   <= r_own0;
         r_blank1 <= r_blank0;
      end
   end

   // ROM data for the tag in stage 1 is on i_rom_rdata now; steer it by owner
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_disp_pixel <= '0;
         r_disp_valid <= 1'b0;
         r_host_rdata <= '0;
         r_host_ack   <= 1'b0;
      end else begin
         r_disp_valid <= (r_own1 == OWN_DISP);
         if (r_own1 == OWN_DISP) begin
            r_disp_pixel <= r_blank1 ? BLANK_PIXEL : bus.i_rom_rdata;
         end
         r_host_ack <= (r_own1 == OWN_HOST);
         if (r_own1 == OWN_HOST) begin
            r_host_rdata <= bus.i_rom_rdata;
         end
      end
   end

   assign bus.o_rom_addr   = r_rom_addr;
   assign bus.o_disp_pixel = r_disp_pixel;
   assign bus.o_disp_valid = r_disp_valid;
   assign bus.o_host_rdata = r_host_rdata;
   assign bus.o_host_ack   = r_host_ack;

endmodule
`default_nettype wire

// File: tb/tb_vga_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_vga_rom_arbiter
// Brief  : Scoreboard bench for vga_rom_arbiter with a behavioural ROM.
// Rev    : 1.0  initial release
// ============================================================================
module tb_vga_rom_arbiter;

   typedef struct {
      logic [23:0] data;
      int          cyc;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_checks;
   int   n_fail;
   exp_t q_disp[$];
   exp_t q_host[$];
   exp_t e_d;
   exp_t e_h;

   vga_rom_arbiter_if #(.ADDR_WIDTH(24), .DATA_WIDTH(24)) bus ();

   vga_rom_arbiter #(
      .DISPLAY_WIDTH (640),
      .DISPLAY_HEIGHT(480),
      .DATA_WIDTH    (24),
      .ADDR_WIDTH    (24),
      .BLANK_PIXEL   (24'h000000)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   function automatic logic [23:0] rom_word(input logic [23:0] a);
      return a * 24'd3 + 24'h111111;
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ROM: data registered one edge after the address
   always @(posedge clk) bus.i_rom_rdata <= rom_word(bus.o_rom_addr);

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: output presented with nothing expected (cycle %0d)", name, cyc);
   endtask

   always @(negedge clk) begin
      if (bus.o_disp_valid) begin
         if (q_disp.size() == 0) begin
            fail_now("disp_valid_unexpected");
         end else begin
            e_d = q_disp.pop_front();
            check("disp_pixel", 32'(bus.o_disp_pixel), 32'(e_d.data));
            check("disp_latency", 32'(cyc), 32'(e_d.cyc));
         end
      end
      if (bus.o_host_ack) begin
         if (q_host.size() == 0) begin
            fail_now("host_ack_unexpected");
         end else begin
            e_h = q_host.pop_front();
            check("host_rdata", 32'(bus.o_host_rdata), 32'(e_h.data));
            check("host_ack_latency", 32'(cyc), 32'(e_h.cyc));
         end
      end
   end

   // Called just after a negedge; returns at the following negedge
   task automatic disp_px(input int x, input int y);
      logic [23:0] a;
      logic        oor;
      exp_t        e;
      a   = 24'(y * 640 + x);
      oor = (x >= 640) || (y >= 480);
      bus.i_disp_active = 1'b1;
      bus.i_disp_x      = 10'(x);
      bus.i_disp_y      = 10'(y);
      e.data = oor ? 24'h000000 : rom_word(a);
      e.cyc  = cyc + 3;
      q_disp.push_back(e);
      @(posedge clk); #1;
      if (!oor) check("disp_rom_addr", 32'(bus.o_rom_addr), 32'(a));
      @(negedge clk);
   endtask

   task automatic push_host(input logic [23:0] addr);
      exp_t e;
      e.data = rom_word(addr);
      e.cyc  = cyc + 3;
      q_host.push_back(e);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_rom_addr"},   32'(bus.o_rom_addr),   32'h0);
      check({tag, "_disp_pixel"}, 32'(bus.o_disp_pixel), 32'h0);
      check({tag, "_disp_valid"}, 32'(bus.o_disp_valid), 32'h0);
      check({tag, "_host_rdata"}, 32'(bus.o_host_rdata), 32'h0);
      check({tag, "_host_ack"},   32'(bus.o_host_ack),   32'h0);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n             = 1'b0;
      bus.i_disp_active = 1'b0;
      bus.i_disp_x      = '0;
      bus.i_disp_y      = '0;
      bus.i_host_req    = 1'b0;
      bus.i_host_addr   = '0;

      // Reset state, held and after release
      repeat (5) @(negedge clk);
      check_idle_outputs("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_idle_outputs("post_reset");

      // Back-to-back display stream, row 1
      for (int x = 0; x < 4; x++) disp_px(x, 1);
      // Out-of-range and last in-range pixel
      disp_px(640, 0);
      disp_px(0, 480);
      disp_px(639, 479);
      bus.i_disp_active = 1'b0;
      repeat (4) @(negedge clk);

      // Host read during blanking; req held through DONE to catch a regrant
      bus.i_host_req  = 1'b1;
      bus.i_host_addr = 24'h000123;
      push_host(24'h000123);
      @(posedge clk); #1;
      check("host_grant_addr", 32'(bus.o_rom_addr), 32'h000123);
      repeat (3) @(negedge clk);
      check("host_ack_seen", 32'(bus.o_host_ack), 32'h1);
      @(negedge clk);
      check("host_ack_one_cycle", 32'(bus.o_host_ack), 32'h0);
      bus.i_host_req = 1'b0;
      repeat (5) @(negedge clk);
      check("host_rdata_hold", 32'(bus.o_host_rdata), 32'(rom_word(24'h000123)));

      // Contention: display keeps ownership for 10 cycles, then host wins
      bus.i_host_req  = 1'b1;
      bus.i_host_addr = 24'h0ABCDE;
      for (int x = 0; x < 10; x++) disp_px(x, 2);
      bus.i_disp_active = 1'b0;
      push_host(24'h0ABCDE);
      @(posedge clk); #1;
      check("contention_grant_addr", 32'(bus.o_rom_addr), 32'h0ABCDE);
      @(negedge clk);
      disp_px(10, 2);
      disp_px(11, 2);
      check("contention_ack", 32'(bus.o_host_ack), 32'h1);
      bus.i_host_req = 1'b0;
      disp_px(12, 2);
      bus.i_disp_active = 1'b0;
      repeat (5) @(negedge clk);

      // Reset while the host read is in WAIT1: dropped, then reissued
      bus.i_host_req  = 1'b1;
      bus.i_host_addr = 24'h000055;
      @(posedge clk); #1;
      check("midreset_grant_addr", 32'(bus.o_rom_addr), 32'h000055);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("midreset_rom_addr", 32'(bus.o_rom_addr), 32'h0);
      check("midreset_host_ack", 32'(bus.o_host_ack), 32'h0);
      rst_n = 1'b1;
      push_host(24'h000055);
      @(posedge clk); #1;
      check("reissue_grant_addr", 32'(bus.o_rom_addr), 32'h000055);
      repeat (3) @(negedge clk);
      check("reissue_ack", 32'(bus.o_host_ack), 32'h1);
      bus.i_host_req = 1'b0;
      repeat (6) @(negedge clk);

      check("disp_queue_drained", 32'(q_disp.size()), 32'h0);
      check("host_queue_drained", 32'(q_host.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
